// File: rtl/mem_stage_if.sv
// Execute->memory->write-back handshake and payload bundle for mem_stage.
// slave: the memory stage's view; master: the surrounding pipeline/environment.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RF_AW  = 5
);
  logic                          ws_allowin;
  logic                          ms_allowin;
  logic                          es2ms_valid;
  logic [DATA_W+RF_AW+1:0]       es_rf_zip;
  logic [DATA_W-1:0]             es_pc;
  logic [2:0]                    es_ld_op;
  logic [DATA_W-1:0]             data_sram_rdata;
  logic [DATA_W+RF_AW+1:0]       ms_rf_zip;
  logic                          ms2ws_valid;
  logic [2*DATA_W+RF_AW:0]       ms2ws_bus;

  modport slave (
    input  ws_allowin, es2ms_valid, es_rf_zip, es_pc, es_ld_op, data_sram_rdata,
    output ms_allowin, ms_rf_zip, ms2ws_valid, ms2ws_bus
  );

  modport master (
    output ws_allowin, es2ms_valid, es_rf_zip, es_pc, es_ld_op, data_sram_rdata,
    input  ms_allowin, ms_rf_zip, ms2ws_valid, ms2ws_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: forms register write data from ALU result or SRAM load data.
// Optional MEM_SUBWORD_LOAD_EN enables byte/half extraction with sign/zero extension.
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RF_AW  = 5
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  ms_if
);

  logic              ms_valid_q, ms_valid_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              rf_we_q, rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;

  logic              ms_ready_go;
  logic              ms_allowin;
  logic              accept;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] load_result;
  logic [DATA_W-1:0] ms_rf_wdata;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
  assign accept      = ms_if.es2ms_valid & ms_allowin;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    pc_d           = pc_q;
    hold_vld_d     = hold_vld_q;
    rdata_buf_d    = rdata_buf_q;
    if (ms_allowin) begin
      ms_valid_d = ms_if.es2ms_valid;
    end
    // SRAM data is only valid in the first cycle; latch it so a stall survives re-driven reads.
    if (accept) begin
      {res_from_mem_d, rf_we_d, rf_waddr_d, alu_result_d} = ms_if.es_rf_zip;
      pc_d       = ms_if.es_pc;
      hold_vld_d = 1'b0;
    end else if (ms_valid_q && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      rdata_buf_d = ms_if.data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      pc_q           <= '0;
      hold_vld_q     <= 1'b0;
      rdata_buf_q    <= '0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      pc_q           <= pc_d;
      hold_vld_q     <= hold_vld_d;
      rdata_buf_q    <= rdata_buf_d;
    end
  end

  assign mem_word = hold_vld_q ? rdata_buf_q : ms_if.data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } ld_op_e;

  ld_op_e      ld_op_q, ld_op_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_op_d = ld_op_q;
    if (accept) begin
      ld_op_d = ld_op_e'(ms_if.es_ld_op);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_op_q <= LD_W;
    end else begin
      ld_op_q <= ld_op_d;
    end
  end

  // Half-word select ignores address bit 0: misaligned halves read the aligned half.
  always_comb begin
    ld_byte = mem_word[{alu_result_q[1:0], 3'b000} +: 8];
    ld_half = alu_result_q[1] ? mem_word[31:16] : mem_word[15:0];
    case (ld_op_q)
      LD_B:    load_result = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_BU:   load_result = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_H:    load_result = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LD_HU:   load_result = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_result = mem_word;
    endcase
  end
`else
  logic unused_ld_op;
  assign unused_ld_op = ^ms_if.es_ld_op;
  assign load_result  = mem_word;
`endif

  assign ms_rf_wdata = res_from_mem_q ? load_result : alu_result_q;

  assign ms_if.ms_allowin  = ms_allowin;
  assign ms_if.ms2ws_valid = ms_valid_q & ms_ready_go;
  assign ms_if.ms2ws_bus   = {rf_we_q, rf_waddr_q, ms_rf_wdata, pc_q};
  assign ms_if.ms_rf_zip   = {res_from_mem_q & ms_valid_q, rf_we_q & ms_valid_q,
                              rf_waddr_q, ms_rf_wdata};

endmodule
